obj_points: RTL and testbench
=============================

# obj_points

Upstream point extractor for `obj_fc`. Consumes a raster-ordered 1-bit foreground-mask AXI-Stream and tracks per frame the four extreme foreground pixels: top, bottom, left and right. At end of frame it emits them as one `CCW`-bit beat on the points stream that `obj_fc` reads on `s_points_*`. It also keeps frame and pixel counters and protocol-error flags for the register bank.

## Interface
- `IC`, 48: active columns per line
- `IR`, 32: active rows per frame
- `ICW`, 11: column coordinate width
- `IRW`, 11: row coordinate width
- `CCW`, 4*(ICW+IRW): points payload width
- `REG_DW`, 32: register word width
- Clock and reset: one clock; reset is asynchronous and active-low.
- `clk`, in, 1: sole clock, rising edge
- `rstn`, in, 1: async assert, sync release, active-low reset
- `s_pix_tdata`, in, 1: 1 = foreground pixel
- `s_pix_tvalid`, in, 1: pixel valid
- `s_pix_tready`, out, 1: pixel accepted when valid & ready
- `s_pix_tuser`, in, 4: {sof, eof, sol, eol}
- `s_pix_tlast`, in, 1: end of line, equals eol
- `m_points_tdata`, out, CCW: {top, bottom, left, right}, each {y[IRW-1:0], x[ICW-1:0]}, top in MSBs
- `m_points_tvalid`, out, 1: result valid
- `m_points_tready`, in, 1: downstream ready
- `m_points_tuser`, out, 4: {1, 1, 0, empty}
- `m_points_tlast`, out, 1: always 1 when valid
- `reg_cnt`, out, REG_DW*2: [REG_DW-1:0] frames emitted; [2*REG_DW-1:REG_DW] foreground pixels in last emitted frame
- `reg_sta`, out, REG_DW: [0] in-frame; [1] result pending; [2] last frame empty; other bits 0
- `reg_err`, out, REG_DW: sticky error bits; [0] sof mid-frame; [1] eol at x≠IC-1; [2] eof at (x,y)≠(IC-1,IR-1); other bits 0; cleared only by reset

## Operation
- **Handshake.** A beat is accepted when `s_pix_tvalid & s_pix_tready`. Counters and accumulators change only on accepted beats.
- **Position counters.** Each beat is tagged with the current (x, y).
  - After a beat: x increments.
  - eol: x wraps to 0 and y increments.
  - eof: x and y both go to 0.
  - sof: the beat is taken as (0, 0) regardless of the counters.
- **State machine.** States are IDLE and FRAME.
  - IDLE→FRAME on an accepted sof beat.
  - FRAME→IDLE on an accepted eof beat.
  - Beats accepted in IDLE without sof are counted but not accumulated. They set `reg_err[0]` only if they carry eof.
  - sof in FRAME sets `reg_err[0]`, clears the accumulators and restarts the frame at the sof beat.
  - A beat with both sof and eof is a one-pixel frame.
- **Accumulation.** Foreground beats only; comparisons are unsigned.
  - top: first hit in the frame.
  - bottom: every hit overwrites it.
  - left: replaced when x < left.x (strictly less).
  - right: replaced when x > right.x (strictly greater).
  - Ties therefore keep the smallest y.
  - An internal `hit` flag marks that at least one foreground pixel was seen.
  - The pixel counter saturates at all-ones.
- **Emission.** The accepted eof beat is included in the accumulation. The final values are copied to the output register:
  - `m_points_tvalid` = 1, `tuser` = {1,1,0,~hit}.
  - If no hit: tdata = 0 and `reg_sta[2]` = 1.
  - The frame counter increments (wraps) and the accumulators clear.
- **Backpressure.** `s_pix_tready = ~m_points_tvalid | m_points_tready`. Input stalls only while a result is pending and unaccepted.

## Timing
- All outputs reset to 0. `s_pix_tready` is 1 one cycle after `rstn` deasserts.
- Latency: `m_points_tvalid` rises on the clock edge that accepts eof, so it is visible the next cycle.
- tdata, tuser and tlast stay stable while valid & ~ready. Valid drops on the cycle after acceptance unless a new eof is accepted on that same edge; in that case the output reloads and valid stays 1.
- eof accepted on the edge where the pending result is accepted: legal, no loss. Readiness is guaranteed by the tready equation.
- Reset mid-frame: the partial frame is discarded, no beat is emitted, and counters return to 0.
- Error flags set one cycle after the offending beat is accepted.

## Test plan
All scenarios use IC=48, IR=32, ICW=IRW=11.

1. **Single pixel.** One foreground pixel at (5,5), m_tready=1.
   - One beat, one cycle after eof: all four points (x=5, y=5), tuser=4'b1100, tlast=1.
   - reg_cnt frames=1, pixels=1.
2. **Rectangle.** Foreground over x 10..20, y 3..8.
   - top=(10,3), bottom=(20,8), left=(10,3), right=(20,3); pixels=66.
3. **Empty frame.** No foreground pixels.
   - tdata=0, tuser=4'b1101, reg_sta[2]=1.
4. **Backpressure.** m_tready=0 for 50 cycles after frame 1 eof; frame 2 follows immediately.
   - tdata held constant and s_pix_tready=0 during the stall.
   - After release, frame 2 result is correct, with no pixel lost or duplicated.
5. **Truncated frame.** sof injected at frame position (7,10).
   - reg_err[0]=1.
   - Result reflects only pixels from the new sof onward.
6. **Reset mid-frame.** rstn low for 3 cycles at y=10.
   - All outputs 0 and no beat emitted.
   - The next full frame produces a correct result, with frames=1.

Source files
------------

// File: rtl/obj_points.sv
// Extreme-point extractor: tracks top/bottom/left/right foreground pixels
// of a raster-ordered 1-bit mask and emits them once per frame.
`timescale 1ns/1ps
module obj_points #(
  parameter int IC     = 48,
  parameter int IR     = 32,
  parameter int ICW    = 11,
  parameter int IRW    = 11,
  parameter int CCW    = 4*(ICW+IRW),
  parameter int REG_DW = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              s_pix_tdata,
  input  logic              s_pix_tvalid,
  output logic              s_pix_tready,
  input  logic [3:0]        s_pix_tuser,
  input  logic              s_pix_tlast,
  output logic [CCW-1:0]    m_points_tdata,
  output logic              m_points_tvalid,
  input  logic              m_points_tready,
  output logic [3:0]        m_points_tuser,
  output logic              m_points_tlast,
  output logic [2*REG_DW-1:0] reg_cnt,
  output logic [REG_DW-1:0] reg_sta,
  output logic [REG_DW-1:0] reg_err
);

  typedef struct packed {
    logic [IRW-1:0] y;
    logic [ICW-1:0] x;
  } pt_t;

  typedef enum logic {
    IDLE,
    FRAME
  } state_t;

  state_t state;
  state_t state_nx;

  logic sof;
  logic eof;
  logic eol;
  logic unused_in;

  assign sof = s_pix_tuser[3];
  assign eof = s_pix_tuser[2];
  assign eol = s_pix_tuser[0];
  assign unused_in = ^{s_pix_tuser[1], s_pix_tlast};

  logic rdy_q;
  logic fire;
  logic active;
  logic fg;
  logic emit;

  logic [ICW-1:0] x_cnt;
  logic [IRW-1:0] y_cnt;
  pt_t            pos;

  pt_t              top_q;
  pt_t              bot_q;
  pt_t              lft_q;
  pt_t              rgt_q;
  logic             hit_q;
  logic [REG_DW-1:0] pix_q;

  pt_t              top_b;
  pt_t              bot_b;
  pt_t              lft_b;
  pt_t              rgt_b;
  logic             hit_b;
  logic [REG_DW-1:0] pix_b;

  pt_t              top_n;
  pt_t              bot_n;
  pt_t              lft_n;
  pt_t              rgt_n;
  logic             hit_n;
  logic [REG_DW-1:0] pix_n;

  logic [REG_DW-1:0] frames_q;
  logic [REG_DW-1:0] pix_last_q;
  logic              empty_q;
  logic [2:0]        err_q;
  logic [2:0]        err_set;

  // Ready is held low through reset and for the first cycle after release.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rdy_q <= 1'b0;
    end else begin
      rdy_q <= 1'b1;
    end
  end

  assign s_pix_tready = rdy_q & (~m_points_tvalid | m_points_tready);
  assign fire         = s_pix_tvalid & s_pix_tready;

  always_comb begin
    pos = '0;
    if (!sof) begin
      pos.x = x_cnt;
      pos.y = y_cnt;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      x_cnt <= '0;
      y_cnt <= '0;
    end else if (fire) begin
      if (eof) begin
        x_cnt <= '0;
        y_cnt <= '0;
      end else if (eol) begin
        x_cnt <= '0;
        y_cnt <= pos.y + IRW'(1);
      end else begin
        x_cnt <= pos.x + ICW'(1);
        y_cnt <= pos.y;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    if (fire) begin
      if (sof) begin
        state_nx = eof ? IDLE : FRAME;
      end else if (eof) begin
        state_nx = IDLE;
      end
    end
  end

  assign active = fire & (sof | (state == FRAME));
  assign fg     = active & s_pix_tdata;
  assign emit   = active & eof;

  // A sof beat starts from cleared accumulators, even mid-frame.
  always_comb begin
    top_b = top_q;
    bot_b = bot_q;
    lft_b = lft_q;
    rgt_b = rgt_q;
    hit_b = hit_q;
    pix_b = pix_q;
    if (sof) begin
      top_b = '0;
      bot_b = '0;
      lft_b = '0;
      rgt_b = '0;
      hit_b = 1'b0;
      pix_b = '0;
    end
  end

  always_comb begin
    top_n = top_b;
    bot_n = bot_b;
    lft_n = lft_b;
    rgt_n = rgt_b;
    hit_n = hit_b;
    pix_n = pix_b;
    if (fg) begin
      hit_n = 1'b1;
      bot_n = pos;
      if (pix_b != '1) begin
        pix_n = pix_b + REG_DW'(1);
      end
      if (!hit_b) begin
        top_n = pos;
      end
      if (!hit_b || (pos.x < lft_b.x)) begin
        lft_n = pos;
      end
      if (!hit_b || (pos.x > rgt_b.x)) begin
        rgt_n = pos;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      top_q <= '0;
      bot_q <= '0;
      lft_q <= '0;
      rgt_q <= '0;
      hit_q <= 1'b0;
      pix_q <= '0;
    end else if (emit) begin
      top_q <= '0;
      bot_q <= '0;
      lft_q <= '0;
      rgt_q <= '0;
      hit_q <= 1'b0;
      pix_q <= '0;
    end else if (active) begin
      top_q <= top_n;
      bot_q <= bot_n;
      lft_q <= lft_n;
      rgt_q <= rgt_n;
      hit_q <= hit_n;
      pix_q <= pix_n;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_points_tvalid <= 1'b0;
      m_points_tdata  <= '0;
      m_points_tuser  <= '0;
      frames_q        <= '0;
      pix_last_q      <= '0;
      empty_q         <= 1'b0;
    end else if (emit) begin
      m_points_tvalid <= 1'b1;
      m_points_tdata  <= hit_n ? {top_n, bot_n, lft_n, rgt_n} : '0;
      m_points_tuser  <= {3'b110, ~hit_n};
      frames_q        <= frames_q + REG_DW'(1);
      pix_last_q      <= pix_n;
      empty_q         <= ~hit_n;
    end else if (m_points_tready) begin
      m_points_tvalid <= 1'b0;
    end
  end

  assign m_points_tlast = m_points_tvalid;

  always_comb begin
    err_set    = '0;
    err_set[0] = fire & ((sof & (state == FRAME)) |
                         (eof & ~sof & (state == IDLE)));
    err_set[1] = fire & eol & (pos.x != ICW'(IC-1));
    err_set[2] = fire & eof &
                 ((pos.x != ICW'(IC-1)) | (pos.y != IRW'(IR-1)));
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      err_q <= '0;
    end else begin
      err_q <= err_q | err_set;
    end
  end

  assign reg_cnt = {pix_last_q, frames_q};
  assign reg_sta = {{(REG_DW-3){1'b0}}, empty_q, m_points_tvalid,
                    (state == FRAME)};
  assign reg_err = {{(REG_DW-3){1'b0}}, err_q};

endmodule

// File: tb/tb_obj_points.sv
// Directed bench for obj_points: raster frames in, scoreboard of
// expected point beats, register checks after each drain.
`timescale 1ns/1ps
module tb_obj_points;

  localparam int IC     = 48;
  localparam int IR     = 32;
  localparam int ICW    = 11;
  localparam int IRW    = 11;
  localparam int CCW    = 4*(ICW+IRW);
  localparam int REG_DW = 32;

  logic              clk;
  logic              rstn;
  logic              s_pix_tdata;
  logic              s_pix_tvalid;
  logic              s_pix_tready;
  logic [3:0]        s_pix_tuser;
  logic              s_pix_tlast;
  logic [CCW-1:0]    m_points_tdata;
  logic              m_points_tvalid;
  logic              m_points_tready;
  logic [3:0]        m_points_tuser;
  logic              m_points_tlast;
  logic [2*REG_DW-1:0] reg_cnt;
  logic [REG_DW-1:0] reg_sta;
  logic [REG_DW-1:0] reg_err;

  obj_points #(
    .IC(IC), .IR(IR), .ICW(ICW), .IRW(IRW), .CCW(CCW), .REG_DW(REG_DW)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .s_pix_tdata(s_pix_tdata),
    .s_pix_tvalid(s_pix_tvalid),
    .s_pix_tready(s_pix_tready),
    .s_pix_tuser(s_pix_tuser),
    .s_pix_tlast(s_pix_tlast),
    .m_points_tdata(m_points_tdata),
    .m_points_tvalid(m_points_tvalid),
    .m_points_tready(m_points_tready),
    .m_points_tuser(m_points_tuser),
    .m_points_tlast(m_points_tlast),
    .reg_cnt(reg_cnt),
    .reg_sta(reg_sta),
    .reg_err(reg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [CCW-1:0] data;
    logic [3:0]     user;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit fg(input int mode, input int x, input int y);
    case (mode)
      0: return (x == 5) && (y == 5);
      1: return (x >= 10) && (x <= 20) && (y >= 3) && (y <= 8);
      3: return ((x == 30) && (y == 20)) || ((x == 2) && (y == 25));
      4: return (x >= 30) && (x <= 40) && (y >= 12) && (y <= 20);
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [21:0] pt(input int x, input int y);
    logic [10:0] yy;
    logic [10:0] xx;
    yy = 11'(y);
    xx = 11'(x);
    return {yy, xx};
  endfunction

  // Extremes derived from definitions: raster-first, raster-last,
  // column-first scans for min/max x with smallest y.
  task automatic model(input int mode, output exp_t e);
    int tx = -1, ty = -1, bx = -1, by = -1;
    int lx = -1, ly = -1, rx = -1, ry = -1;
    for (int y = 0; y < IR; y++)
      for (int x = 0; x < IC; x++)
        if (fg(mode, x, y)) begin
          if (tx < 0) begin tx = x; ty = y; end
          bx = x; by = y;
        end
    for (int x = 0; x < IC && lx < 0; x++)
      for (int y = 0; y < IR && lx < 0; y++)
        if (fg(mode, x, y)) begin lx = x; ly = y; end
    for (int x = IC-1; x >= 0 && rx < 0; x--)
      for (int y = 0; y < IR && rx < 0; y++)
        if (fg(mode, x, y)) begin rx = x; ry = y; end
    if (tx < 0) begin
      e.data = '0;
      e.user = 4'b1101;
    end else begin
      e.data = {pt(tx, ty), pt(bx, by), pt(lx, ly), pt(rx, ry)};
      e.user = 4'b1100;
    end
  endtask

  task automatic beat(input logic d, input logic sof, input logic eof,
                      input logic sol, input logic eol);
    logic r;
    int n;
    s_pix_tdata  = d;
    s_pix_tuser  = {sof, eof, sol, eol};
    s_pix_tlast  = eol;
    s_pix_tvalid = 1'b1;
    n = 0;
    r = 1'b0;
    while (!r && n < 1000) begin
      @(negedge clk);
      r = s_pix_tready;
      @(posedge clk);
      #1;
      n++;
    end
    chk("handshake", r, 1'b1);
  endtask

  task automatic send_frame(input int mode, input int sx, input int sy);
    exp_t e;
    bit done;
    bit last;
    done = 0;
    for (int y = 0; y < IR && !done; y++)
      for (int x = 0; x < IC && !done; x++) begin
        if (x == sx && y == sy) begin
          done = 1;
        end else begin
          last = (x == IC-1) && (y == IR-1);
          if (last) begin
            model(mode, e);
            q.push_back(e);
          end
          beat(fg(mode, x, y), (x == 0 && y == 0), last, (x == 0),
               (x == IC-1));
          if (last) chk("eof_latency", m_points_tvalid, 1'b1);
        end
      end
    s_pix_tvalid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 5000) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain", q.size(), 0);
  endtask

  always @(negedge clk) begin
    if (rstn && m_points_tvalid && m_points_tready) begin
      checks++;
      assert (q.size() != 0) else begin
        errors++;
        $error("FAIL extra_beat observed=unexpected beat expected=none");
      end
      if (q.size() != 0) begin
        exp_t e;
        e = q.pop_front();
        chk("tdata", m_points_tdata, e.data);
        chk("tuser", m_points_tuser, e.user);
        chk("tlast", m_points_tlast, 1'b1);
      end
    end
  end

  initial begin
    exp_t e;
    rstn            = 1'b0;
    s_pix_tdata     = 1'b0;
    s_pix_tvalid    = 1'b0;
    s_pix_tuser     = '0;
    s_pix_tlast     = 1'b0;
    m_points_tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", m_points_tvalid, 1'b0);
    chk("rst_tdata", m_points_tdata, '0);
    chk("rst_ready", s_pix_tready, 1'b0);
    chk("rst_cnt", reg_cnt, '0);
    chk("rst_sta", reg_sta, '0);
    chk("rst_err", reg_err, '0);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    chk("ready_after_rst", s_pix_tready, 1'b1);

    send_frame(0, -1, -1);
    drain();
    chk("single_cnt", reg_cnt, {32'd1, 32'd1});

    send_frame(1, -1, -1);
    drain();
    chk("rect_cnt", reg_cnt, {32'd66, 32'd2});
    chk("rect_sta", reg_sta, 32'h0);

    send_frame(2, -1, -1);
    drain();
    chk("empty_cnt", reg_cnt, {32'd0, 32'd3});
    chk("empty_sta", reg_sta, 32'h4);

    m_points_tready = 1'b0;
    send_frame(1, -1, -1);
    fork
      send_frame(4, -1, -1);
      begin
        repeat (50) begin
          @(posedge clk);
          #1;
          chk("stall_hold", m_points_tdata, q[0].data);
          chk("stall_ready", s_pix_tready, 1'b0);
        end
        m_points_tready = 1'b1;
      end
    join
    drain();
    chk("bp_cnt", reg_cnt, {32'd99, 32'd5});
    chk("bp_err", reg_err, 32'h0);

    send_frame(1, 7, 10);
    chk("trunc_inframe", reg_sta, 32'h1);
    send_frame(3, -1, -1);
    drain();
    chk("trunc_err", reg_err, 32'h1);
    chk("trunc_cnt", reg_cnt, {32'd2, 32'd6});

    e.data = '0;
    e.user = 4'b1100;
    q.push_back(e);
    e.user = 4'b1101;
    q.push_back(e);
    beat(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    beat(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    s_pix_tvalid = 1'b0;
    drain();
    chk("onepix_err", reg_err, 32'h5);
    chk("onepix_cnt", reg_cnt, {32'd0, 32'd8});
    chk("onepix_sta", reg_sta, 32'h4);

    send_frame(4, 0, 10);
    rstn = 1'b0;
    #1;
    chk("mid_rst_valid", m_points_tvalid, 1'b0);
    chk("mid_rst_ready", s_pix_tready, 1'b0);
    chk("mid_rst_cnt", reg_cnt, '0);
    chk("mid_rst_sta", reg_sta, '0);
    chk("mid_rst_err", reg_err, '0);
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_ready1", s_pix_tready, 1'b1);
    send_frame(4, -1, -1);
    drain();
    chk("post_rst_cnt", reg_cnt, {32'd99, 32'd1});
    chk("post_rst_err", reg_err, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
